// File: rtl/rgb_led_pwm_ctrl.sv
// Three-channel RGB LED PWM with prescaler and blink cadence; register writes land in one cycle.
// Outputs are registered one clock after the counter state; there is no backpressure.
module rgb_led_pwm_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       led_cs,
  input  logic       led_den,
  input  logic [3:0] led_addr,
  input  logic [7:0] led_wdata,
  input  logic       led_exe,
  input  logic       drv_en,
  input  logic       cur_en,
  output logic [2:0] rgb_pwm,
  output logic [2:0] rgb,
  output logic       led_on
);

  logic [2:0][7:0] duty_q, duty_d;
  logic            en_q, en_d;
  logic [7:0]      presc_q, presc_d;
  logic [7:0]      on_q, on_d;
  logic [7:0]      off_q, off_d;
  logic [7:0]      pc_q, pc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      ph_q, ph_d;
  logic            blink_on_q, blink_on_d;
  logic [2:0]      rgb_pwm_q, rgb_pwm_d;
  logic            led_on_q, led_on_d;

  logic       active;
  logic       tick;
  logic       period_end;
  logic       blink_eff;
  logic [8:0] ph_inc;

  always_comb begin
    duty_d     = duty_q;
    en_d       = en_q;
    presc_d    = presc_q;
    on_d       = on_q;
    off_d      = off_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    blink_on_d = blink_on_q;
    rgb_pwm_d  = '0;

    if (led_cs && led_den) begin
      case (led_addr)
        4'h1:    duty_d[0] = led_wdata;
        4'h2:    duty_d[1] = led_wdata;
        4'h3:    duty_d[2] = led_wdata;
        4'h8:    en_d      = led_wdata[7];
        4'h9:    presc_d   = led_wdata;
        4'hA:    on_d      = led_wdata;
        4'hB:    off_d     = led_wdata;
        default: ;
      endcase
    end

    active     = led_exe & en_q;
    tick       = active & (pc_q >= presc_q);
    period_end = tick & (cnt_q == 8'hFF);
    ph_inc     = {1'b0, ph_q} + 9'd1;

    if (!active) begin
      pc_d       = '0;
      cnt_d      = '0;
      ph_d       = '0;
      blink_on_d = 1'b1;
    end else begin
      pc_d  = tick ? 8'd0 : pc_q + 8'd1;
      cnt_d = tick ? cnt_q + 8'd1 : cnt_q;
      // >= against the limit lets a lowered ON/OFF time end the phase at once
      if (period_end) begin
        if (off_q == 8'd0) begin
          blink_on_d = 1'b1;
          ph_d       = '0;
        end else if (on_q == 8'd0) begin
          blink_on_d = 1'b0;
          ph_d       = '0;
        end else if (blink_on_q) begin
          if (ph_inc >= {1'b0, on_q}) begin
            blink_on_d = 1'b0;
            ph_d       = '0;
          end else begin
            ph_d = ph_inc[7:0];
          end
        end else begin
          if (ph_inc >= {1'b0, off_q}) begin
            blink_on_d = 1'b1;
            ph_d       = '0;
          end else begin
            ph_d = ph_inc[7:0];
          end
        end
      end
    end

    blink_eff = (off_q == 8'd0) | (blink_on_q & (on_q != 8'd0));
    led_on_d  = active & blink_eff;
    for (int i = 0; i < 3; i++) begin
      rgb_pwm_d[i] = led_on_d & (cnt_q < duty_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q     <= '0;
      en_q       <= 1'b0;
      presc_q    <= '0;
      on_q       <= '0;
      off_q      <= '0;
      pc_q       <= '0;
      cnt_q      <= '0;
      ph_q       <= '0;
      blink_on_q <= 1'b1;
      rgb_pwm_q  <= '0;
      led_on_q   <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      en_q       <= en_d;
      presc_q    <= presc_d;
      on_q       <= on_d;
      off_q      <= off_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      blink_on_q <= blink_on_d;
      rgb_pwm_q  <= rgb_pwm_d;
      led_on_q   <= led_on_d;
    end
  end

  assign rgb_pwm = rgb_pwm_q;
  assign led_on  = led_on_q;
  assign rgb     = ~(rgb_pwm_q & {3{drv_en & cur_en}});

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// Directed bench for rgb_led_pwm_ctrl: duty ratios, prescaler, blink cadence, enables and reset.
module tb_rgb_led_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       led_cs, led_den;
  logic [3:0] led_addr;
  logic [7:0] led_wdata;
  logic       led_exe, drv_en, cur_en;
  logic [2:0] rgb_pwm, rgb;
  logic       led_on;

  int n_chk  = 0;
  int n_pass = 0;

  rgb_led_pwm_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .led_cs    (led_cs),
    .led_den   (led_den),
    .led_addr  (led_addr),
    .led_wdata (led_wdata),
    .led_exe   (led_exe),
    .drv_en    (drv_en),
    .cur_en    (cur_en),
    .rgb_pwm   (rgb_pwm),
    .rgb       (rgb),
    .led_on    (led_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    led_cs = 1'b1; led_den = 1'b1; led_addr = a; led_wdata = d;
    @(negedge clk);
    led_cs = 1'b0; led_den = 1'b0;
  endtask

  task automatic wait_rise(input string tag);
    int w = 0;
    while (!led_on && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check(tag, int'(led_on), 1);
  endtask

  // Measures the run of led_on == val starting at the current sample.
  task automatic measure(input logic val, output int len, output int r_hi, output int nz);
    len = 0; r_hi = 0; nz = 0;
    while (led_on == val && len < 4000) begin
      len++;
      if (rgb_pwm[0]) r_hi++;
      if (rgb_pwm != 3'b000) nz++;
      @(negedge clk);
    end
  endtask

  initial begin
    int c0, c1, c2, bad, run, best, len, rhi, nz;
    rst = 1'b1; led_cs = 1'b0; led_den = 1'b0; led_addr = '0; led_wdata = '0;
    led_exe = 1'b0; drv_en = 1'b1; cur_en = 1'b1;
    #23;
    check("rst_rgb", int'(rgb), 7);
    check("rst_pwm", int'(rgb_pwm), 0);
    check("rst_led_on", int'(led_on), 0);
    @(negedge clk); rst = 1'b0;

    // exe high but CR0 enable bit clear (other bits set): stays idle
    led_exe = 1'b1;
    wr(4'h8, 8'h7F);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (rgb_pwm != 3'b000 || led_on || rgb != 3'b111) bad++;
    end
    check("idle_cr0_off", bad, 0);

    // PRESC=0 duty ratios
    wr(4'h9, 8'h00); wr(4'h1, 8'h40); wr(4'h2, 8'h00); wr(4'h3, 8'hFF);
    wr(4'h8, 8'h80);
    repeat (5) @(negedge clk);
    c0 = 0; c1 = 0; c2 = 0; bad = 0;
    repeat (256) begin
      @(negedge clk);
      c0 += int'(rgb_pwm[0]); c1 += int'(rgb_pwm[1]); c2 += int'(rgb_pwm[2]);
      if (rgb != ~rgb_pwm) bad++;
    end
    check("duty_r_40", c0, 64);
    check("duty_g_00", c1, 0);
    check("duty_b_ff", c2, 255);
    check("rgb_inv", bad, 0);

    // PRESC=3, DUTY_R=0x80
    wr(4'h8, 8'h00); wr(4'h9, 8'h03); wr(4'h1, 8'h80); wr(4'h8, 8'h80);
    repeat (8) @(negedge clk);
    c0 = 0; c2 = 0;
    repeat (1024) begin
      @(negedge clk);
      c0 += int'(rgb_pwm[0]); c2 += int'(rgb_pwm[2]);
    end
    check("presc3_r_hi", c0, 512);
    check("presc3_b_hi", c2, 1020);
    run = 0; best = 0;
    repeat (2048) begin
      @(negedge clk);
      run = rgb_pwm[0] ? run + 1 : 0;
      if (run > best) best = run;
    end
    check("presc3_r_run", best, 512);

    // Blink ON=2 OFF=1 with PRESC=0
    wr(4'h8, 8'h00); wr(4'h9, 8'h00); wr(4'h1, 8'hFF);
    wr(4'hA, 8'h02); wr(4'hB, 8'h01); wr(4'h8, 8'h80);
    wait_rise("blink_rise1");
    measure(1'b1, len, rhi, nz);
    check("blink_on_len", len, 512);
    check("blink_on_r_hi", rhi, 510);
    measure(1'b0, len, rhi, nz);
    check("blink_off_len", len, 256);
    check("blink_off_pwm", nz, 0);
    measure(1'b1, len, rhi, nz);
    check("blink_on_len2", len, 512);

    // Drop exe mid-ON-period with a coinciding DUTY_R write
    wait_rise("blink_rise2");
    repeat (100) @(negedge clk);
    check("pre_drop_r", int'(rgb_pwm[0]), 1);
    led_exe = 1'b0;
    led_cs = 1'b1; led_den = 1'b1; led_addr = 4'h1; led_wdata = 8'h10;
    @(negedge clk);
    led_cs = 1'b0; led_den = 1'b0;
    check("drop_pwm", int'(rgb_pwm), 0);
    check("drop_led_on", int'(led_on), 0);
    repeat (3) @(negedge clk);
    led_exe = 1'b1;
    @(negedge clk);
    check("rerun_led_on", int'(led_on), 1);
    check("rerun_r", int'(rgb_pwm[0]), 1);
    measure(1'b1, len, rhi, nz);
    check("rerun_on_len", len, 512);
    check("rerun_r_hi", rhi, 32);

    // ON_TIME=0, OFF_TIME=1: permanently off
    wr(4'hA, 8'h00);
    repeat (2) @(negedge clk);
    c0 = 0; c1 = 0;
    repeat (600) begin
      @(negedge clk);
      c0 += int'(led_on);
      if (rgb_pwm != 3'b000) c1++;
    end
    check("perm_off_led", c0, 0);
    check("perm_off_pwm", c1, 0);

    // OFF_TIME=0: permanently on
    wr(4'hB, 8'h00);
    repeat (2) @(negedge clk);
    c0 = 0;
    repeat (600) begin
      @(negedge clk);
      if (!led_on) c0++;
    end
    check("perm_on_low", c0, 0);

    // Driver / current enables gate the pads only
    drv_en = 1'b0;
    bad = 0; c2 = 0;
    repeat (256) begin
      @(negedge clk);
      if (rgb != 3'b111) bad++;
      c2 += int'(rgb_pwm[2]);
    end
    check("drv_off_rgb", bad, 0);
    check("drv_off_b_hi", c2, 255);
    drv_en = 1'b1; cur_en = 1'b0;
    bad = 0; c2 = 0;
    repeat (256) begin
      @(negedge clk);
      if (rgb != 3'b111) bad++;
      c2 += int'(rgb_pwm[2]);
    end
    check("cur_off_rgb", bad, 0);
    check("cur_off_b_hi", c2, 255);
    cur_en = 1'b1;
    @(negedge clk);
    check("en_back_rgb_b", int'(rgb[2]), 0);

    // Async reset mid-run
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_rgb", int'(rgb), 7);
    check("arst_pwm", int'(rgb_pwm), 0);
    check("arst_led_on", int'(led_on), 0);
    @(negedge clk); rst = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (rgb_pwm != 3'b000 || led_on) bad++;
    end
    check("post_rst_idle", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
